// File: rtl/conv_sched.sv
// conv_sched: streams an image through a 3-row line buffer, issues every 3x3 window
// to one shared external MAC and returns the results as a raster output stream.
module conv_sched #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int DW      = 13,
  parameter int MAC_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_pix,
  output logic            mac_en,
  output logic [3*DW-1:0] mac_row0,
  output logic [3*DW-1:0] mac_row1,
  output logic [3*DW-1:0] mac_row2,
  input  logic [DW-1:0]   mac_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_pix,
  output logic [4:0]      out_row,
  output logic [4:0]      out_col
);
  localparam int LW = $clog2(MAC_LAT + 1);
  typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] wr_q, wr_d, left_q, left_d, r1, r2;
  logic [4:0] col_q, col_d, orow_q, orow_d, oc_q, oc_d;
  logic [LW-1:0] lat_q, lat_d;
  logic busy_q, busy_d, done_q, done_d, in_ready_q, in_ready_d, mac_en_q, mac_en_d;
  logic out_valid_q, out_valid_d;
  logic [3*DW-1:0] row0_q, row0_d, row1_q, row1_d, row2_q, row2_d;
  logic [DW-1:0] out_pix_q, out_pix_d;
  logic [DW-1:0] lb [3][IMG_W];
  logic in_hs, out_hs, last_col;
  assign in_hs = in_valid & in_ready_q;
  assign out_hs = out_valid_q & out_ready;
  assign last_col = col_q == 5'(IMG_W - 1);
  // wr_q points at the oldest row once a fill completes; r1/r2 are the next two slots
  assign r1 = wr_q == 2'd2 ? 2'd0 : wr_q + 2'd1;
  assign r2 = wr_q == 2'd0 ? 2'd2 : wr_q - 2'd1;
  always_ff @(posedge clk)
    if (state_q == FILL && in_hs) lb[wr_q][col_q] <= in_pix;
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    left_d = left_q;
    col_d = col_q;
    orow_d = orow_q;
    oc_d = oc_q;
    lat_d = lat_q;
    busy_d = busy_q;
    done_d = 1'b0;
    in_ready_d = in_ready_q;
    mac_en_d = 1'b0;
    out_valid_d = out_valid_q;
    row0_d = row0_q;
    row1_d = row1_q;
    row2_d = row2_q;
    out_pix_d = out_pix_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FILL;
        busy_d = 1'b1;
        in_ready_d = 1'b1;
        left_d = 2'd3;
        wr_d = 2'd0;
        col_d = '0;
        orow_d = '0;
        oc_d = '0;
      end
      FILL: if (in_hs) begin
        col_d = last_col ? 5'd0 : col_q + 5'd1;
        if (last_col) begin
          wr_d = r1;
          left_d = left_q - 2'd1;
          if (left_q == 2'd1) begin
            state_d = ISSUE;
            in_ready_d = 1'b0;
            oc_d = '0;
          end
        end
      end
      ISSUE: begin
        mac_en_d = 1'b1;
        row0_d = {lb[wr_q][oc_q + 5'd2], lb[wr_q][oc_q + 5'd1], lb[wr_q][oc_q]};
        row1_d = {lb[r1][oc_q + 5'd2], lb[r1][oc_q + 5'd1], lb[r1][oc_q]};
        row2_d = {lb[r2][oc_q + 5'd2], lb[r2][oc_q + 5'd1], lb[r2][oc_q]};
        lat_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LW'(MAC_LAT)) begin
          out_pix_d = mac_out;
          out_valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: if (out_hs) begin
        out_valid_d = 1'b0;
        if (oc_q != 5'(IMG_W - 3)) begin
          oc_d = oc_q + 5'd1;
          state_d = ISSUE;
        end else if (orow_q != 5'(IMG_H - 3)) begin
          orow_d = orow_q + 5'd1;
          left_d = 2'd1;
          in_ready_d = 1'b1;
          state_d = FILL;
        end else begin
          done_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q <= '0;
      left_q <= '0;
      col_q <= '0;
      orow_q <= '0;
      oc_q <= '0;
      lat_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      in_ready_q <= 1'b0;
      mac_en_q <= 1'b0;
      out_valid_q <= 1'b0;
      row0_q <= '0;
      row1_q <= '0;
      row2_q <= '0;
      out_pix_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      left_q <= left_d;
      col_q <= col_d;
      orow_q <= orow_d;
      oc_q <= oc_d;
      lat_q <= lat_d;
      busy_q <= busy_d;
      done_q <= done_d;
      in_ready_q <= in_ready_d;
      mac_en_q <= mac_en_d;
      out_valid_q <= out_valid_d;
      row0_q <= row0_d;
      row1_q <= row1_d;
      row2_q <= row2_d;
      out_pix_q <= out_pix_d;
    end
  assign busy = busy_q;
  assign done = done_q;
  assign in_ready = in_ready_q;
  assign mac_en = mac_en_q;
  assign mac_row0 = row0_q;
  assign mac_row1 = row1_q;
  assign mac_row2 = row2_q;
  assign out_valid = out_valid_q;
  assign out_pix = out_pix_q;
  assign out_row = orow_q;
  assign out_col = oc_q;
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: drives whole frames through conv_sched with a stub 9-input adder MAC
// and compares every output against a window sum computed from the pixel pattern.
`timescale 1ns/1ps
module tb_conv_sched #(parameter int MAC_LAT = 1);
  localparam int IMG_W = 32, IMG_H = 32, DW = 13;
  localparam int OW = IMG_W - 2, OH = IMG_H - 2, TMO = 5000;
  logic clk = 1'b0, rst_n, start, busy, done, in_valid, in_ready, mac_en, out_valid, out_ready;
  logic [DW-1:0] in_pix, mac_out, out_pix, win_sum;
  logic [3*DW-1:0] mac_row0, mac_row1, mac_row2;
  logic [4:0] out_row, out_col;
  logic [DW-1:0] pipe [MAC_LAT];
  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  bit abort;
  conv_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .mac_en(mac_en), .mac_row0(mac_row0), .mac_row1(mac_row1), .mac_row2(mac_row2),
    .mac_out(mac_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_row(out_row), .out_col(out_col));
  always #5 clk = ~clk;
  // stub MAC: plain sum of the nine window pixels, delayed MAC_LAT cycles; junk when idle
  always_comb begin
    win_sum = '0;
    for (int k = 0; k < 3; k++)
      win_sum = win_sum + mac_row0[k*DW +: DW] + mac_row1[k*DW +: DW] + mac_row2[k*DW +: DW];
  end
  always @(posedge clk) begin
    pipe[0] <= mac_en ? win_sum : '1;
    for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mac_out = pipe[MAC_LAT-1];
  always @(negedge clk) if (done) done_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] pix(input int mode, input int r, input int c);
    case (mode)
      0: return DW'(1);
      1: return DW'(c);
      2: return DW'(r);
      default: return DW'(r * 37 + c * 11 + r * c * 5);
    endcase
  endfunction
  function automatic logic [DW-1:0] expv(input int mode, input int r, input int c);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) s = s + pix(mode, r + i, c + j);
    return s;
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_mac_en"}, 32'(mac_en), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_pix"}, 32'(out_pix), 0);
    chk({tag, "_out_row"}, 32'(out_row), 0);
    chk({tag, "_out_col"}, 32'(out_col), 0);
    chk({tag, "_mac_rows"}, 32'(|{mac_row0, mac_row1, mac_row2}), 0);
  endtask
  task automatic drive(input int mode, input bit gaps);
    int t;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        if (gaps) while ($urandom_range(0, 1) == 1 && !abort) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_pix = pix(mode, r, c);
        t = 0;
        while (!in_ready && !abort && t < TMO) begin
          @(posedge clk); #1;
          t++;
        end
        if (abort) begin
          in_valid = 1'b0;
          return;
        end
        if (!in_ready) begin
          chk("in_ready_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
    in_valid = 1'b0;
  endtask
  task automatic recv(input int mode, input bit stalls, input bit glitch, input int abort_at);
    int t, n, r, c;
    logic [DW-1:0] held;
    for (int k = 0; k < OW * OH; k++) begin
      r = k / OW;
      c = k % OW;
      t = 0;
      while (!out_valid && t < TMO) begin
        @(posedge clk); #1;
        t++;
      end
      if (!out_valid) begin
        chk("out_valid_timeout", 0, 1);
        abort = 1'b1;
        return;
      end
      if (glitch && k % 37 == 5) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      n = stalls ? $urandom_range(0, 5) : 0;
      held = out_pix;
      repeat (n) begin
        @(posedge clk); #1;
        chk("hold_pix", 32'(out_pix), 32'(held));
        chk("hold_valid", 32'(out_valid), 1);
      end
      chk("out_pix", 32'(out_pix), 32'(expv(mode, r, c)));
      chk("out_row", 32'(out_row), r);
      chk("out_col", 32'(out_col), c);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("valid_after_hs", 32'(out_valid), 0);
      if (k + 1 == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("abort");
        abort = 1'b1;
        return;
      end
    end
  endtask
  task automatic frame(input int mode, input bit gaps, input bit stalls, input bit glitch,
                       input int abort_at);
    int d0;
    d0 = done_cnt;
    abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    fork
      drive(mode, gaps);
      recv(mode, stalls, glitch, abort_at);
    join
    if (abort_at > 0) begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk); #1;
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_busy", 32'(busy), 0);
    end else begin
      repeat (4) @(posedge clk); #1;
      chk("done_once", done_cnt - d0, 1);
      chk("busy_after_done", 32'(busy), 0);
      chk("no_extra_valid", 32'(out_valid), 0);
      chk("in_ready_idle", 32'(in_ready), 0);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_pix = '0;
    out_ready = 1'b0;
    abort = 1'b0;
    #1 rst_n = 1'b0;
    #2 chk_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 0);
    chk("idle_busy", 32'(busy), 0);
    frame(0, 0, 0, 0, 0);
    frame(1, 0, 0, 0, 0);
    frame(2, 0, 0, 0, 0);
    frame(3, 1, 1, 0, 0);
    frame(1, 1, 1, 1, 0);
    frame(2, 0, 0, 0, 100);
    frame(3, 1, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
